mem_ctrl: RTL and testbench

//  Memory controller feeding the IF stage (and the MEM stage) from a byte-wide synchronous RAM.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_if.sv | 36 +++
 rtl/mem_ctrl_byte_assembler.sv | 32 +++
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serialising memory controller: FSM states, request owner
// and access-width codes.
package mem_ctrl_pkg;

  localparam int AddrWDefault = 17;

  typedef enum logic [1:0] {
    MemCtrlIdle  = 2'd0,
    MemCtrlRead  = 2'd1,
    MemCtrlWrite = 2'd2
  } mem_state_e;

  typedef enum logic {
    OwnerIf  = 1'b0,
    OwnerMem = 1'b1
  } owner_e;

  localparam logic [1:0] MemWidthByte = 2'b00;
  localparam logic [1:0] MemWidthHalf = 2'b01;
  localparam logic [1:0] MemWidthWord = 2'b10;

  // Code 2'b11 is served as a full word.
  function automatic logic [2:0] widthToBytes(input logic [1:0] width);
    case (width)
      MemWidthByte: return 3'd1;
      MemWidthHalf: return 3'd2;
      MemWidthWord: return 3'd4;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the pipeline (IF and MEM stages), the controller and
// the byte-wide RAM. The slave modport is the controller's view.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = AddrWDefault
) ();

  logic              if_re;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_re;
  logic              mem_we;
  logic [1:0]        mem_width;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  modport slave (
    input  if_re, if_addr, mem_re, mem_we, mem_width, mem_addr, mem_wdata, ram_rdata,
    output if_data, if_done, mem_rdata, mem_done, busy, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output if_re, if_addr, mem_re, mem_we, mem_width, mem_addr, mem_wdata, ram_rdata,
    input  if_data, if_done, mem_rdata, mem_done, busy, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/mem_ctrl_byte_assembler.sv
// Collects RAM read bytes into a little-endian word; lanes never written stay zero
// because the buffer is cleared while the controller is idle.
module mem_ctrl_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic [3:0]  laneEn;

  // word_o already includes the byte being captured this cycle, so the final lane
  // can be forwarded straight into the result register.
  always_comb begin
    laneEn = capture_i ? (4'b0001 << lane_i) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = laneEn[i] ? byte_i : buf_q[8*i +: 8];
    end
    buf_d = clear_i ? 32'h0 : word_o;
  end

  always_ff @(posedge clk) begin
    if (rst) buf_q <= 32'h0;
    else     buf_q <= buf_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises 32-bit IF/MEM requests into byte accesses on a synchronous byte-wide RAM;
// MEM has priority over IF, and each completion is signalled by a registered done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = AddrWDefault
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  mem_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nBytes_q, nBytes_d;
  logic [ADDR_W-1:0] baseAddr_q, baseAddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ifDone_q, ifDone_d;
  logic              memDone_q, memDone_d;
  logic [31:0]       ifData_q, ifData_d;
  logic [31:0]       memRdata_q, memRdata_d;

  logic [31:0] assembled;
  logic        captureEn;
  logic [1:0]  laneSel;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

  // The RAM returns a byte one cycle after its address, so lane (cnt-1) is captured.
  assign captureEn = (state_q == MemCtrlRead) && (cnt_q != 3'd0);
  assign laneSel   = cnt_q[1:0] - 2'd1;

  mem_ctrl_byte_assembler u_assembler (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == MemCtrlIdle),
    .capture_i(captureEn),
    .lane_i   (laneSel),
    .byte_i   (bus.ram_rdata),
    .word_o   (assembled)
  );

  // No accept while a done pulse is out: the finished requester still holds its request.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    nBytes_d   = nBytes_q;
    baseAddr_d = baseAddr_q;
    wdata_d    = wdata_q;
    ifData_d   = ifData_q;
    memRdata_d = memRdata_q;
    ifDone_d   = 1'b0;
    memDone_d  = 1'b0;
    case (state_q)
      MemCtrlIdle: begin
        cnt_d = 3'd0;
        if (!ifDone_q && !memDone_q) begin
          if (bus.mem_we) begin
            state_d    = MemCtrlWrite;
            owner_d    = OwnerMem;
            nBytes_d   = widthToBytes(bus.mem_width);
            baseAddr_d = bus.mem_addr[ADDR_W-1:0];
            wdata_d    = bus.mem_wdata;
          end else if (bus.mem_re) begin
            state_d    = MemCtrlRead;
            owner_d    = OwnerMem;
            nBytes_d   = widthToBytes(bus.mem_width);
            baseAddr_d = bus.mem_addr[ADDR_W-1:0];
          end else if (bus.if_re) begin
            state_d    = MemCtrlRead;
            owner_d    = OwnerIf;
            nBytes_d   = 3'd4;
            baseAddr_d = bus.if_addr[ADDR_W-1:0];
          end
        end
      end
      MemCtrlRead: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == nBytes_q) begin
          state_d = MemCtrlIdle;
          cnt_d   = 3'd0;
          if (owner_q == OwnerIf) begin
            ifDone_d = 1'b1;
            ifData_d = assembled;
          end else begin
            memDone_d  = 1'b1;
            memRdata_d = assembled;
          end
        end
      end
      MemCtrlWrite: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == nBytes_q - 3'd1) begin
          state_d   = MemCtrlIdle;
          cnt_d     = 3'd0;
          memDone_d = 1'b1;
        end
      end
      default: state_d = MemCtrlIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MemCtrlIdle;
      owner_q    <= OwnerIf;
      cnt_q      <= 3'd0;
      nBytes_q   <= 3'd0;
      baseAddr_q <= '0;
      wdata_q    <= 32'h0;
      ifDone_q   <= 1'b0;
      memDone_q  <= 1'b0;
      ifData_q   <= 32'h0;
      memRdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      nBytes_q   <= nBytes_d;
      baseAddr_q <= baseAddr_d;
      wdata_q    <= wdata_d;
      ifDone_q   <= ifDone_d;
      memDone_q  <= memDone_d;
      ifData_q   <= ifData_d;
      memRdata_q <= memRdata_d;
    end
  end

  // The write strobe is cut as soon as reset rises so an aborted write stops at once.
  assign bus.ram_we    = (state_q == MemCtrlWrite) && !rst;
  assign bus.ram_addr  = (state_q == MemCtrlIdle) ? '0 : baseAddr_q + ADDR_W'(cnt_q);
  assign bus.ram_wdata = (state_q == MemCtrlWrite) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.busy      = (state_q != MemCtrlIdle);
  assign bus.if_done   = ifDone_q;
  assign bus.mem_done  = memDone_q;
  assign bus.if_data   = ifData_q;
  assign bus.mem_rdata = memRdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-array RAM model plus a shadow memory that
// predicts read data, done latency and written bytes from the access rules.
module tb_mem_ctrl;

  localparam int AddrW   = 17;
  localparam int RamSize = 1 << AddrW;

  logic clk = 1'b0;
  logic rst;

  mem_ctrl_if #(.ADDR_W(AddrW)) bus ();

  mem_ctrl #(.ADDR_W(AddrW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:RamSize-1] = '{default: 8'h00};
  logic [7:0]  shadow [0:RamSize-1];
  logic        preloadEn = 1'b0;
  logic [16:0] preloadAddr = '0;
  logic [7:0]  preloadData = '0;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] expIfData = 32'h0;
  logic [31:0] expMemRdata = 32'h0;

  // Synchronous byte RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (preloadEn) ram[preloadAddr] <= preloadData;
    else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input int n);
    logic [31:0] value;
    logic [16:0] a;
    value = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr[16:0] + 17'(i);
      value = value | (32'(shadow[a]) << (8 * i));
    end
    return value;
  endfunction

  task automatic preloadByte(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    shadow[a]   = d;
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic dropRequests();
    bus.if_re  = 1'b0;
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
  endtask

  // op: 0 = IF fetch, 1 = MEM read, 2 = MEM write
  task automatic applyStimulus(input int op, input logic [1:0] width, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit dropEarly);
    int          n;
    int          latency;
    int          doneAt;
    int          waitCycles;
    logic [31:0] expData;
    logic [16:0] a;
    waitCycles = 0;
    @(negedge clk);
    while ((bus.busy || bus.if_done || bus.mem_done) && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("idle before request", 32'(waitCycles < 50), 32'd1);
    n = (op == 0) ? 4 : (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    latency = (op == 2) ? n + 1 : n + 2;
    if (op == 0) begin
      bus.if_re   = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.mem_we    = (op == 2);
      bus.mem_re    = (op == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.mem_width = width;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end
    doneAt = 0;
    for (int k = 1; k <= 30 && doneAt == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("busy after accept", 32'(bus.busy), 32'd1);
        if (dropEarly) dropRequests();
      end
      if ((op == 0 && bus.if_done) || (op != 0 && bus.mem_done)) doneAt = k;
    end
    checkOutput("done latency", 32'(doneAt), 32'(latency));
    checkOutput("busy in done cycle", 32'(bus.busy), 32'd0);
    dropRequests();
    if (op == 2) begin
      for (int i = 0; i < n; i++) begin
        a = addr[16:0] + 17'(i);
        shadow[a] = wdata[8*i +: 8];
        checkOutput("ram byte written", 32'(ram[a]), 32'(shadow[a]));
      end
      checkOutput("mem_rdata held", bus.mem_rdata, expMemRdata);
      checkOutput("if_data held", bus.if_data, expIfData);
    end else begin
      expData = modelRead(addr, n);
      if (op == 0) begin
        expIfData = expData;
        checkOutput("if_data", bus.if_data, expIfData);
        checkOutput("mem_rdata held", bus.mem_rdata, expMemRdata);
      end else begin
        expMemRdata = expData;
        checkOutput("mem_rdata", bus.mem_rdata, expMemRdata);
        checkOutput("if_data held", bus.if_data, expIfData);
      end
    end
  endtask

  initial begin
    int          memAt;
    int          ifAt;
    int          overlap;
    int          doneSeen;
    int          op;
    logic [31:0] addr;
    logic [31:0] highBits;

    for (int i = 0; i < RamSize; i++) shadow[i] = 8'h00;
    rst           = 1'b1;
    bus.if_re     = 1'b0;
    bus.if_addr   = 32'h0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_width = 2'b00;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset if_done", 32'(bus.if_done), 32'd0);
    checkOutput("reset mem_done", 32'(bus.mem_done), 32'd0);
    checkOutput("reset ram_we", 32'(bus.ram_we), 32'd0);
    checkOutput("reset ram_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("reset ram_wdata", 32'(bus.ram_wdata), 32'd0);
    checkOutput("reset if_data", bus.if_data, 32'd0);
    checkOutput("reset mem_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0;

    preloadByte(17'h00000, 8'h13);
    preloadByte(17'h00001, 8'h05);
    preloadByte(17'h00002, 8'h00);
    preloadByte(17'h00003, 8'h00);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("fetch addi word", bus.if_data, 32'h00000513);

    applyStimulus(2, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(1, 2'b10, 32'h10, 32'h0, 1'b0);
    checkOutput("word readback", bus.mem_rdata, 32'hDEADBEEF);
    applyStimulus(1, 2'b00, 32'h11, 32'h0, 1'b0);
    checkOutput("byte read 0x11", bus.mem_rdata, 32'h000000BE);
    applyStimulus(1, 2'b01, 32'h12, 32'h0, 1'b0);
    checkOutput("half read 0x12", bus.mem_rdata, 32'h0000DEAD);
    applyStimulus(1, 2'b11, 32'h10, 32'h0, 1'b1);
    checkOutput("width 11 dropped request", bus.mem_rdata, 32'hDEADBEEF);

    // IF and MEM raised together: MEM served first, IF accepted the cycle after mem_done.
    @(negedge clk);
    bus.if_re     = 1'b1;
    bus.if_addr   = 32'h0;
    bus.mem_re    = 1'b1;
    bus.mem_width = 2'b10;
    bus.mem_addr  = 32'h10;
    memAt = 0;
    ifAt = 0;
    overlap = 0;
    for (int k = 1; k <= 40 && (memAt == 0 || ifAt == 0); k++) begin
      @(negedge clk);
      if (bus.mem_done && bus.if_done) overlap++;
      if (bus.mem_done && memAt == 0) begin
        memAt = k;
        bus.mem_re = 1'b0;
        checkOutput("arb mem_rdata", bus.mem_rdata, modelRead(32'h10, 4));
      end
      if (bus.if_done && ifAt == 0) begin
        ifAt = k;
        bus.if_re = 1'b0;
        checkOutput("arb if_data", bus.if_data, modelRead(32'h0, 4));
      end
    end
    checkOutput("arb mem_done cycle", 32'(memAt), 32'd6);
    checkOutput("arb if_done cycle", 32'(ifAt), 32'd13);
    checkOutput("arb done overlap", 32'(overlap), 32'd0);
    dropRequests();

    preloadByte(17'h1FFFE, 8'hA1);
    preloadByte(17'h1FFFF, 8'hB2);
    applyStimulus(1, 2'b10, 32'hFFFFFFFE, 32'h0, 1'b0);
    checkOutput("wrap word read", bus.mem_rdata, 32'h0513B2A1);

    // Reset raised in cycle 2 of a word write: only byte 0 may land.
    @(negedge clk);
    bus.mem_we    = 1'b1;
    bus.mem_width = 2'b10;
    bus.mem_addr  = 32'h40;
    bus.mem_wdata = 32'h11223344;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.mem_we = 1'b0;
    @(negedge clk);
    checkOutput("ram_we cut by reset", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("busy after abort", 32'(bus.busy), 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.mem_done || bus.if_done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("no done after abort", 32'(doneSeen), 32'd0);
    shadow[17'h40] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort ram byte", 32'(ram[17'h40 + 17'(i)]), 32'(shadow[17'h40 + 17'(i)]));
    end
    expIfData = 32'h0;
    expMemRdata = 32'h0;
    applyStimulus(1, 2'b10, 32'h40, 32'h0, 1'b0);
    checkOutput("read after abort", bus.mem_rdata, 32'h00000044);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      highBits = $urandom & 32'hFFFE0000;
      if ($urandom_range(0, 3) == 0) addr = highBits | (32'h1FFFC + 32'($urandom_range(0, 3)));
      else                           addr = highBits | 32'($urandom_range(0, 63));
      applyStimulus(op, 2'($urandom_range(0, 3)), addr, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
